// File: rtl/mealy_frame_driver.sv
// Serial frame driver / response collector for the lab4 Mealy sequence FSM.
// Resets the FSM, shifts a word MSB-first onto its input and captures its same-cycle output.
module mealy_frame_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             fsm_in,
  input  logic             fsm_out,
  output logic             fsm_rst_n,
  output logic             busy,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] tx_shift_r, tx_shift_nx_s;
  logic [WIDTH-2:0] rx_shift_r, rx_shift_nx_s;
  logic [WIDTH-1:0] rx_word_s;
  logic [CW-1:0]    cnt_r, cnt_nx_s;
  logic [WIDTH-1:0] rx_data_r, rx_data_nx_s;
  logic             tx_ready_r, busy_r, rx_valid_r, fsm_in_r;

  // Word completed by the bit the FSM is answering in this cycle.
  assign rx_word_s = {rx_shift_r, fsm_out};

  // Next-state and datapath update decode.
  always_comb begin
    state_nx_s    = state_r;
    tx_shift_nx_s = tx_shift_r;
    rx_shift_nx_s = rx_shift_r;
    cnt_nx_s      = cnt_r;
    rx_data_nx_s  = rx_data_r;
    case (state_r)
      IDLE: begin
        if (tx_valid && tx_ready_r) begin
          tx_shift_nx_s = tx_data;
          cnt_nx_s      = {CW{1'b0}};
          state_nx_s    = INIT;
        end else begin
          state_nx_s = IDLE;
        end
      end
      INIT: begin
        state_nx_s = SHIFT;
      end
      SHIFT: begin
        rx_shift_nx_s = rx_word_s[WIDTH-2:0];
        tx_shift_nx_s = {tx_shift_r[WIDTH-2:0], 1'b0};
        cnt_nx_s      = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if (cnt_r == CW'(WIDTH - 1)) begin
          rx_data_nx_s = rx_word_s;
          state_nx_s   = DONE;
        end else begin
          state_nx_s = SHIFT;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs (decoded from the next state).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      tx_shift_r <= {WIDTH{1'b0}};
      rx_shift_r <= {(WIDTH-1){1'b0}};
      cnt_r      <= {CW{1'b0}};
      rx_data_r  <= {WIDTH{1'b0}};
      tx_ready_r <= 1'b1;
      busy_r     <= 1'b0;
      rx_valid_r <= 1'b0;
      fsm_in_r   <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      tx_shift_r <= tx_shift_nx_s;
      rx_shift_r <= rx_shift_nx_s;
      cnt_r      <= cnt_nx_s;
      rx_data_r  <= rx_data_nx_s;
      tx_ready_r <= (state_nx_s == IDLE);
      busy_r     <= (state_nx_s != IDLE);
      rx_valid_r <= (state_nx_s == DONE);
      fsm_in_r   <= (state_nx_s == SHIFT) ? tx_shift_nx_s[WIDTH-1] : 1'b0;
    end
  end

  // The FSM is held in reset both during INIT and while our own reset is high.
  assign fsm_rst_n = ~(rst | (state_r == INIT));
  assign tx_ready  = tx_ready_r;
  assign busy      = busy_r;
  assign rx_valid  = rx_valid_r;
  assign rx_data   = rx_data_r;
  assign fsm_in    = fsm_in_r;

endmodule

// File: tb/tb_mealy_frame_driver.sv
// Directed bench for mealy_frame_driver driving a small 6-state Mealy FSM model.
module tb_mealy_frame_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       fsm_in;
  logic       fsm_out;
  logic       fsm_rst_n;
  logic       busy;
  logic [7:0] rx_data;
  logic       rx_valid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rxv_cnt = 0;
  int acc_q[$];
  logic [7:0] rx_q[$];

  mealy_frame_driver #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_data(tx_data), .fsm_in(fsm_in), .fsm_out(fsm_out),
    .fsm_rst_n(fsm_rst_n), .busy(busy), .rx_data(rx_data), .rx_valid(rx_valid)
  );

  always #5 clk = ~clk;

  // Sequence FSM model: synchronous active-low reset, Mealy output.
  typedef enum logic [2:0] {S0, SA, SB, SC, SP, SQ} fst_t;
  fst_t fst, fst_nx;

  always_comb begin
    fst_nx  = fst;
    fsm_out = 1'b0;
    case (fst)
      S0: begin fst_nx = fsm_in ? SA : S0; fsm_out = fsm_in;  end
      SA: begin fst_nx = fsm_in ? SB : SA; fsm_out = ~fsm_in; end
      SB: begin fst_nx = fsm_in ? SC : SP; fsm_out = 1'b1;    end
      SC: begin fst_nx = fsm_in ? SC : SP; fsm_out = 1'b1;    end
      SP: begin fst_nx = fsm_in ? S0 : SQ; fsm_out = ~fsm_in; end
      SQ: begin fst_nx = SA;               fsm_out = 1'b0;    end
      default: begin fst_nx = S0; fsm_out = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!fsm_rst_n) fst <= S0;
    else            fst <= fst_nx;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor away from the active edge: acceptances and response pulses.
  always @(negedge clk) begin
    if (rx_valid) begin
      rxv_cnt = rxv_cnt + 1;
      rx_q.push_back(rx_data);
    end
    if (tx_valid && tx_ready) acc_q.push_back(cyc);
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check("ready_timeout", {15'd0, ok}, 16'd1);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [7:0] exp, input bit glitch);
    logic [7:0] seq;
    int rst_low;
    int rdy_hi;
    int v0;
    wait_ready();
    tx_data  = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = ~d;
    check("init_rst_n", {15'd0, fsm_rst_n}, 16'd0);
    check("init_busy", {15'd0, busy}, 16'd1);
    check("init_fsm_in", {15'd0, fsm_in}, 16'd0);
    seq = 8'd0;
    rst_low = 0;
    rdy_hi = 0;
    v0 = rxv_cnt;
    for (int k = 0; k < 8; k++) begin
      step();
      seq[7-k] = fsm_in;
      if (!fsm_rst_n) rst_low++;
      if (tx_ready) rdy_hi++;
      if (glitch && k == 2) begin
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
      end
      if (glitch && k == 3) tx_valid = 1'b0;
    end
    check("fsm_in_seq", {8'd0, seq}, {8'd0, d});
    check("rst_n_shift", rst_low[15:0], 16'd0);
    check("ready_busy", rdy_hi[15:0], 16'd0);
    check("no_early_rxv", rxv_cnt[15:0], v0[15:0]);
    step();
    check("rx_valid_c10", {15'd0, rx_valid}, 16'd1);
    check("rx_data", {8'd0, rx_data}, {8'd0, exp});
    check("done_ready", {15'd0, tx_ready}, 16'd0);
    step();
    check("rx_valid_c11", {15'd0, rx_valid}, 16'd0);
    check("ready_c11", {15'd0, tx_ready}, 16'd1);
    check("busy_c11", {15'd0, busy}, 16'd0);
    check("rx_hold", {8'd0, rx_data}, {8'd0, exp});
  endtask

  initial begin
    int v0;
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {15'd0, tx_ready}, 16'd1);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_rx_valid", {15'd0, rx_valid}, 16'd0);
    check("rst_rx_data", {8'd0, rx_data}, 16'd0);
    check("rst_fsm_in", {15'd0, fsm_in}, 16'd0);
    check("rst_fsm_rst_n", {15'd0, fsm_rst_n}, 16'd0);
    rst = 1'b0;
    step();

    run_frame(8'h00, 8'h00, 1'b0);
    run_frame(8'hF0, 8'hBD, 1'b0);

    // Reset in the middle of SHIFT: frame abandoned, no response pulse.
    wait_ready();
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    repeat (4) step();
    v0 = rxv_cnt;
    rst = 1'b1;
    #1;
    check("mid_busy", {15'd0, busy}, 16'd0);
    check("mid_rx_data", {8'd0, rx_data}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_n", {15'd0, fsm_rst_n}, 16'd0);
      step();
    end
    rst = 1'b0;
    step();
    check("post_rst_ready", {15'd0, tx_ready}, 16'd1);
    repeat (12) step();
    check("mid_no_rxv", rxv_cnt[15:0], v0[15:0]);

    run_frame(8'hA5, 8'hDA, 1'b0);

    // Back-to-back with tx_valid held high: the INIT reset makes 00 answer 00.
    wait_ready();
    acc_q.delete();
    rx_q.delete();
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    step();
    tx_data = 8'h00;
    repeat (21) step();
    tx_valid = 1'b0;
    repeat (4) step();
    check("b2b_acc_cnt", acc_q.size(), 16'd2);
    check("b2b_rx_cnt", rx_q.size(), 16'd2);
    if (acc_q.size() == 2) check("b2b_period", acc_q[1] - acc_q[0], 16'd11);
    if (rx_q.size() == 2) begin
      check("b2b_rx0", {8'd0, rx_q[0]}, 16'h00BF);
      check("b2b_rx1", {8'd0, rx_q[1]}, 16'h0000);
    end

    // tx_valid pulsed with other data during SHIFT is ignored.
    run_frame(8'hF0, 8'hBD, 1'b1);
    repeat (3) step();
    check("glitch_no_accept", {15'd0, busy}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
